// File: rtl/fifo_stream_drain_if.sv
// ============================================================================
// fifo_stream_drain_if : FIFO read port plus valid/ready stream bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fifo_stream_drain_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  // master = the drain block; slave = FIFO side plus stream sink
  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last
  );
endinterface

`default_nettype wire

// File: rtl/fifo_stream_drain.sv
// ============================================================================
// fifo_stream_drain : drains a registered-output FIFO into a framed stream
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_stream_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN    = 4
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  input  wire logic           enable_i,
  fifo_stream_drain_if.master bus_io,
  output logic                pkt_done_o,
  output logic                busy_o
);

  localparam int                BEAT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  rd_pending_q;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  pkt_done_q, pkt_done_d;

  logic                  w_valid;
  logic                  w_last;
  logic                  w_pop;
  logic                  w_rd_en;
  logic [2:0]            w_level;

  assign w_valid = (occ_q != 2'd0);
  assign w_last  = w_valid & (beat_q == LAST_BEAT);
  assign w_pop   = w_valid & bus_io.m_ready;

  // Words held plus the one in flight, after this cycle's pop, must leave room
  assign w_level = 3'(occ_q) + 3'(rd_pending_q) - 3'(w_pop);
  assign w_rd_en = (state_q == ST_RUN) & enable_i & ~bus_io.fifo_empty & (w_level < 3'd2);

  assign bus_io.fifo_rd_en = w_rd_en;
  assign bus_io.m_valid    = w_valid;
  assign bus_io.m_data     = head_q;
  assign bus_io.m_last     = w_last;
  assign pkt_done_o        = pkt_done_q;
  assign busy_o            = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q;
    head_d     = head_q;
    tail_d     = tail_q;
    beat_d     = beat_q;
    pkt_done_d = w_pop & w_last;

    // fifo_data is only meaningful the cycle after a read was issued
    unique case ({rd_pending_q, w_pop})
      2'b11: begin
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = bus_io.fifo_data;
        end else begin
          head_d = bus_io.fifo_data;
        end
      end
      2'b10: begin
        if (occ_q == 2'd0) begin
          head_d = bus_io.fifo_data;
        end else begin
          tail_d = bus_io.fifo_data;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      default: ;
    endcase

    if (w_pop) begin
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (enable_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable_i) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((occ_q == 2'd0) && !rd_pending_q) begin
          state_d = ST_IDLE;
        end else if (enable_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      occ_q        <= 2'd0;
      head_q       <= '0;
      tail_q       <= '0;
      rd_pending_q <= 1'b0;
      beat_q       <= '0;
      pkt_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      occ_q        <= occ_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      rd_pending_q <= w_rd_en;
      beat_q       <= beat_d;
      pkt_done_q   <= pkt_done_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_stream_drain.sv
// ============================================================================
// tb_fifo_stream_drain : directed bench with a word-sequence reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_stream_drain;

  localparam int DW = 32;
  localparam int PL = 4;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic enable = 1'b0;
  logic pkt_done;
  logic busy;

  fifo_stream_drain_if #(.DATA_WIDTH(DW)) bus ();

  fifo_stream_drain #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable_i   (enable),
    .bus_io     (bus),
    .pkt_done_o (pkt_done),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  // Upstream FIFO: words mem[rd_ptr..wr_ptr-1], registered data_out
  logic [DW-1:0] mem [0:255];
  int            wr_ptr   = 0;
  int            rd_ptr   = 0;
  int            dl_ptr   = 0;
  logic          force_ne = 1'b0;
  logic [DW-1:0] fifo_q   = '0;
  int            cyc      = 0;

  assign bus.fifo_empty = (rd_ptr == wr_ptr) && !force_ne;
  assign bus.fifo_data  = fifo_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_q <= mem[rd_ptr[7:0]];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: stream must be the FIFO word sequence, beat index modulo PL
  int            beat   = 0;
  logic          exp_pd = 1'b0;
  logic          hold   = 1'b0;
  logic [DW-1:0] hold_data;
  logic          hold_last;
  logic [DW-1:0] log_data [$];
  logic          log_last [$];
  int            log_cyc  [$];
  int            pd_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      dl_ptr = wr_ptr;
      beat   = 0;
      exp_pd = 1'b0;
      hold   = 1'b0;
    end else begin
      chk("pkt_done", 64'(pkt_done), 64'(exp_pd));
      if (hold) begin
        chk("hold_valid", 64'(bus.m_valid), 64'(1));
        chk("hold_data", 64'(bus.m_data), 64'(hold_data));
        chk("hold_last", 64'(bus.m_last), 64'(hold_last));
      end
      chk("occ_bound", 64'((rd_ptr - dl_ptr) <= 2), 64'(1));
      if (bus.fifo_rd_en)
        chk("rd_en_legal", 64'(enable && !bus.fifo_empty && busy), 64'(1));
      if (bus.m_valid) begin
        chk("word_was_read", 64'(dl_ptr < rd_ptr), 64'(1));
        chk("m_data", 64'(bus.m_data), 64'(mem[dl_ptr[7:0]]));
        chk("m_last", 64'(bus.m_last), 64'(beat == PL - 1));
      end else begin
        chk("m_last_idle", 64'(bus.m_last), 64'(0));
      end
      if (pkt_done) pd_cnt++;
      exp_pd = 1'b0;
      hold   = 1'b0;
      if (bus.m_valid && bus.m_ready) begin
        exp_pd = (beat == PL - 1);
        log_data.push_back(bus.m_data);
        log_last.push_back(bus.m_last);
        log_cyc.push_back(cyc);
        dl_ptr++;
        beat = (beat + 1) % PL;
      end else if (bus.m_valid) begin
        hold      = 1'b1;
        hold_data = bus.m_data;
        hold_last = bus.m_last;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr++;
  endtask

  task automatic wait_drained(input string name, input int budget);
    int n = 0;
    while (!((dl_ptr == wr_ptr) && !bus.m_valid) && (n < budget)) begin
      tick(1);
      n++;
    end
    chk({name, "_drain_timeout"}, 64'(n < budget), 64'(1));
    tick(2);
  endtask

  task automatic chk_log(input string name, input int base, input int idx,
                         input logic [DW-1:0] d, input logic l);
    if (log_data.size() > base + idx) begin
      chk({name, "_data"}, 64'(log_data[base + idx]), 64'(d));
      chk({name, "_last"}, 64'(log_last[base + idx]), 64'(l));
    end else begin
      chk({name, "_missing"}, 64'(log_data.size()), 64'(base + idx + 1));
    end
  endtask

  initial begin
    int base;
    int pd0;
    int en_cyc;
    int n;

    bus.m_ready = 1'b0;

    // T1: reset held with enable high and FIFO claiming data
    rst_n    = 1'b0;
    enable   = 1'b1;
    force_ne = 1'b1;
    tick(3);
    chk("t1_rd_en", 64'(bus.fifo_rd_en), 64'(0));
    chk("t1_m_valid", 64'(bus.m_valid), 64'(0));
    chk("t1_busy", 64'(busy), 64'(0));
    chk("t1_pkt_done", 64'(pkt_done), 64'(0));
    chk("t1_m_data", 64'(bus.m_data), 64'(0));
    force_ne = 1'b0;
    enable   = 1'b0;
    rst_n    = 1'b1;
    tick(2);
    chk("t1_idle", 64'(busy), 64'(0));

    // T2: full-rate throughput, first beat three cycles after enable
    for (int i = 0; i < 8; i++) push(DW'(32'h10 + i));
    bus.m_ready = 1'b1;
    base   = log_data.size();
    pd0    = pd_cnt;
    en_cyc = cyc;
    enable = 1'b1;
    wait_drained("t2", 60);
    for (int i = 0; i < 8; i++) chk_log("t2_beat", base, i, DW'(32'h10 + i), (i == 3) || (i == 7));
    if (log_cyc.size() >= base + 8) begin
      chk("t2_latency", 64'(log_cyc[base]), 64'(en_cyc + 3));
      chk("t2_back_to_back", 64'(log_cyc[base + 7] - log_cyc[base]), 64'(7));
    end else begin
      chk("t2_beat_count", 64'(log_cyc.size() - base), 64'(8));
    end
    chk("t2_pkt_done_count", 64'(pd_cnt - pd0), 64'(2));

    // T3: backpressure fills both entries and stops reads
    bus.m_ready = 1'b0;
    base = log_data.size();
    for (int i = 0; i < 8; i++) push(DW'(32'h10 + i));
    tick(8);
    chk("t3_valid", 64'(bus.m_valid), 64'(1));
    chk("t3_head", 64'(bus.m_data), 64'(32'h10));
    chk("t3_rd_en", 64'(bus.fifo_rd_en), 64'(0));
    chk("t3_held", 64'(rd_ptr - dl_ptr), 64'(2));
    bus.m_ready = 1'b1;
    wait_drained("t3", 60);
    chk("t3_count", 64'(log_data.size() - base), 64'(8));
    for (int i = 0; i < 8; i++) chk_log("t3_beat", base, i, DW'(32'h10 + i), (i == 3) || (i == 7));

    // T5: single word then empty; stale data_out must not repeat
    base = log_data.size();
    push(32'hAB);
    wait_drained("t5", 30);
    tick(5);
    chk("t5_count", 64'(log_data.size() - base), 64'(1));
    chk_log("t5_beat", base, 0, 32'hAB, 1'b0);
    chk("t5_valid", 64'(bus.m_valid), 64'(0));

    // T4: enable drop after 2nd beat, packet starts at beat 1
    base = log_data.size();
    for (int i = 0; i < 8; i++) push(DW'(32'h40 + i));
    n = 0;
    while ((log_data.size() < base + 2) && (n < 30)) begin
      tick(1);
      n++;
    end
    chk("t4_two_beats", 64'(n < 30), 64'(1));
    enable = 1'b0;
    tick(1);
    chk("t4_drain_busy", 64'(busy), 64'(1));
    n = 0;
    while (busy && (n < 30)) begin
      tick(1);
      n++;
    end
    chk("t4_idle_reached", 64'(busy), 64'(0));
    tick(3);
    chk("t4_held_count", 64'(log_data.size() - base), 64'(4));
    chk("t4_stopped_valid", 64'(bus.m_valid), 64'(0));
    enable = 1'b1;
    wait_drained("t4", 60);
    for (int i = 0; i < 8; i++) chk_log("t4_beat", base, i, DW'(32'h40 + i), (i == 2) || (i == 6));

    // T6: reset with both entries full, then restart from beat 0
    bus.m_ready = 1'b0;
    base = log_data.size();
    for (int i = 0; i < 4; i++) push(DW'(32'h60 + i));
    tick(8);
    chk("t6_full", 64'(rd_ptr - dl_ptr), 64'(2));
    rst_n = 1'b0;
    tick(1);
    chk("t6_valid", 64'(bus.m_valid), 64'(0));
    chk("t6_m_data", 64'(bus.m_data), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_pkt_done", 64'(pkt_done), 64'(0));
    rst_n = 1'b1;
    tick(1);
    for (int i = 0; i < 4; i++) push(DW'(32'h70 + i));
    bus.m_ready = 1'b1;
    wait_drained("t6", 60);
    chk("t6_count", 64'(log_data.size() - base), 64'(4));
    for (int i = 0; i < 4; i++) chk_log("t6_beat", base, i, DW'(32'h70 + i), i == 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
